// File: rtl/floating_divider_seq.sv
// floating_divider_seq
//   Sequential IEEE-754 single-precision divider. The quotient mantissa comes
//   from a radix-2 restoring divider producing one quotient bit per clock.
//   Special operands (Inf/NaN, zero or denormal) skip the iteration and
//   complete one cycle after they are accepted. Denormals are flushed to zero.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   start      in   1   request, sampled only in IDLE
//   a          in  32   dividend, captured on the accepted start edge
//   b          in  32   divisor, captured on the accepted start edge
//   busy       out  1   high from the cycle after start is accepted until done
//   done       out  1   one-cycle pulse when result and flags update
//   result     out 32   quotient, held until the next done
//   overflow   out  1   result exponent overflowed (held after done)
//   exception  out  1   divide-by-zero or Inf/NaN operand (held after done)
//
// Build option
//   FP_DIV_ROUND_EN  defined: round-to-nearest-even; undefined: truncation.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; outputs hold the last result
// S_DIVIDE | 26 restoring-division iterations, one quotient bit each
// S_PACK   | normalise, round, range-check and register the result

module floating_divider_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        exception
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_PACK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic        spec_exc_q, spec_exc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        exception_q, exception_d;

    // Operand classification on the start edge
    logic [7:0]  ea_in, eb_in;
    logic        sign_in;
    logic        is_spec;
    logic [31:0] spec_res_in;
    logic        spec_exc_in;

    always_comb begin
        ea_in       = a[30:23];
        eb_in       = b[30:23];
        sign_in     = a[31] ^ b[31];
        is_spec     = 1'b1;
        spec_res_in = 32'h0000_0000;
        spec_exc_in = 1'b0;
        if (ea_in == 8'hFF || eb_in == 8'hFF) begin
            spec_res_in = 32'h7FC0_0000;
            spec_exc_in = 1'b1;
        end else if (eb_in == 8'h00) begin
            spec_res_in = {sign_in, 8'hFF, 23'h0};
            spec_exc_in = 1'b1;
        end else if (ea_in == 8'h00) begin
            spec_res_in = 32'h0000_0000;
            spec_exc_in = 1'b0;
        end else begin
            is_spec = 1'b0;
        end
    end

    // Restoring-division step: compare, conditionally subtract, then shift
    logic        quo_bit;
    logic [24:0] rem_sub;

    always_comb begin
        quo_bit = (rem_q >= {1'b0, mb_q});
        rem_sub = quo_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    end

    // Normalise and round the finished quotient
    logic [9:0]  exp_raw, exp_rnd;
    logic [22:0] mant_t;
    logic        guard, sticky, round_up;
    logic [23:0] mant_sum;

    always_comb begin
        // Quotient lies in (0.5, 2); a missing integer bit costs one exponent step.
        exp_raw = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127 - {9'd0, ~quo_q[25]};
        if (quo_q[25]) begin
            mant_t = quo_q[24:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 25'd0);
        end else begin
            mant_t = quo_q[23:1];
            guard  = quo_q[0];
            sticky = (rem_q != 25'd0);
        end
`ifdef FP_DIV_ROUND_EN
        round_up = guard & (sticky | mant_t[0]);
`else
        round_up = 1'b0;
`endif
        // A carry out leaves the mantissa field at zero and bumps the exponent.
        mant_sum = {1'b0, mant_t} + {23'd0, round_up};
        exp_rnd  = exp_raw + {9'd0, mant_sum[23]};
    end

`ifndef FP_DIV_ROUND_EN
    logic unused_grs;
    assign unused_grs = guard ^ sticky;
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        spec_d      = spec_q;
        spec_res_d  = spec_res_q;
        spec_exc_d  = spec_exc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        overflow_d  = overflow_q;
        exception_d = exception_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d      = sign_in;
                    ea_d        = ea_in;
                    eb_d        = eb_in;
                    mb_d        = {1'b1, b[22:0]};
                    rem_d       = {2'b01, a[22:0]};
                    quo_d       = 26'd0;
                    cnt_d       = 5'd0;
                    spec_d      = is_spec;
                    spec_res_d  = spec_res_in;
                    spec_exc_d  = spec_exc_in;
                    busy_d      = 1'b1;
                    overflow_d  = 1'b0;
                    exception_d = 1'b0;
                    state_d     = is_spec ? S_PACK : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                quo_d = {quo_q[24:0], quo_bit};
                rem_d = {rem_sub[23:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = S_PACK;
                end
            end
            S_PACK: begin
                if (spec_q) begin
                    result_d    = spec_res_q;
                    exception_d = spec_exc_q;
                    overflow_d  = 1'b0;
                end else if ($signed(exp_rnd) >= 10'sd255) begin
                    result_d   = {sign_q, 8'hFF, 23'h0};
                    overflow_d = 1'b1;
                end else if ($signed(exp_rnd) <= 10'sd0) begin
                    result_d = 32'h0000_0000;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], mant_sum[22:0]};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            ea_q        <= 8'd0;
            eb_q        <= 8'd0;
            mb_q        <= 24'd0;
            rem_q       <= 25'd0;
            quo_q       <= 26'd0;
            cnt_q       <= 5'd0;
            spec_q      <= 1'b0;
            spec_res_q  <= 32'd0;
            spec_exc_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            spec_exc_q  <= spec_exc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            exception_q <= exception_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign exception = exception_q;

endmodule
